// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the four-core data memory arbiter.
// Core side: req/we/core_addr/core_wdata in, grant/done/rdata/busy/xfer_count out.
// Memory side: mem_addr/mem_wdata/mem_we out, mem_rdata in (synchronous RAM, 1-cycle latency).
// slave = arbiter view, master = cores + RAM view.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned N_CORES = 4;

    logic [N_CORES-1:0]        req;
    logic [N_CORES-1:0]        we;
    logic [N_CORES*ADDR_W-1:0] core_addr;
    logic [N_CORES*DATA_W-1:0] core_wdata;
    logic [N_CORES-1:0]        grant;
    logic [N_CORES-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic [15:0]               xfer_count;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req, we, core_addr, core_wdata, mem_rdata,
        output grant, done, rdata, busy, xfer_count, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req, we, core_addr, core_wdata, mem_rdata,
        input  grant, done, rdata, busy, xfer_count, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving four cores access to one synchronous data RAM.
// Each transaction: IDLE (arbitrate) -> ADDR (address + write strobe)
// -> WAIT (RAM read latency, capture rdata) -> DONE (done pulse) -> IDLE.
// Ports: clock, reset (async, active-high), bus (dmem_arbiter_if.slave).
module dmem_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int unsigned N_CORES = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [N_CORES-1:0]   grant_q, grant_d;
    logic [N_CORES-1:0]   done_q, done_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     xfer_q, xfer_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     win_idx_q, win_idx_d;
    logic                 lat_we_q, lat_we_d;

    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic                 win_found;

    // Round-robin search starting one past the last winner, wrapping mod 4.
    always_comb begin
        win_idx   = last_q;
        win_found = 1'b0;
        cand      = last_q;
        for (int unsigned i = 1; i <= N_CORES; i++) begin
            cand = last_q + IDX_W'(i);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State register; every output comes straight from a flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            xfer_q      <= '0;
            last_q      <= IDX_W'(N_CORES - 1);
            win_idx_q   <= '0;
            lat_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            xfer_q      <= xfer_d;
            last_q      <= last_d;
            win_idx_q   <= win_idx_d;
            lat_we_q    <= lat_we_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        xfer_d      = xfer_q;
        last_d      = last_q;
        win_idx_d   = win_idx_q;
        lat_we_d    = lat_we_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = ADDR;
                    win_idx_d   = win_idx;
                    lat_we_d    = bus.we[win_idx];
                    grant_d     = N_CORES'(1) << win_idx;
                    mem_we_d    = bus.we[win_idx];
                    mem_addr_d  = bus.core_addr[win_idx*ADDR_W +: ADDR_W];
                    mem_wdata_d = bus.core_wdata[win_idx*DATA_W +: DATA_W];
                end
            end
            ADDR: begin
                state_d = WAIT;
            end
            WAIT: begin
                // RAM output for the ADDR-cycle address is valid now.
                if (!lat_we_q) begin
                    rdata_d = bus.mem_rdata;
                end
                state_d = DONE;
                done_d  = grant_q;
                xfer_d  = xfer_q + CNT_W'(1);
                last_d  = win_idx_q;
            end
            DONE: begin
                state_d     = IDLE;
                grant_d     = '0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.rdata      = rdata_q;
    assign bus.busy       = busy_q;
    assign bus.xfer_count = xfer_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a small synchronous RAM model.
module tb_dmem_arbiter;
    logic clock;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errors;

    dmem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    dmem_arbiter #(.DATA_W(16), .ADDR_W(16)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int          core;
        logic [15:0] rdata;
        logic [15:0] xc;
        int          cyc;
    } done_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        int          core;
        int          cyc;
    } wr_t;

    done_t dq[$];
    wr_t   wq[$];

    logic [15:0] ram [0:255];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous RAM: read data valid the cycle after the address.
    always @(posedge clock) begin
        if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_done(input int core, input logic [15:0] rd, input logic [15:0] xc, input int c);
        done_t e;
        e.core = core; e.rdata = rd; e.xc = xc; e.cyc = c;
        dq.push_back(e);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d, input int core, input int c);
        wr_t e;
        e.addr = a; e.wdata = d; e.core = core; e.cyc = c;
        wq.push_back(e);
    endtask

    task automatic set_core(input int n, input logic w, input logic [15:0] a, input logic [15:0] d);
        bus.we[n]               = w;
        bus.core_addr[n*16 +: 16]  = a;
        bus.core_wdata[n*16 +: 16] = d;
        bus.req[n]              = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT shows a write strobe or done.
    always @(negedge clock) begin
        chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        if (!bus.busy) begin
            chk("idle_mem_addr", 32'(bus.mem_addr), 32'd0);
            chk("idle_mem_wdata", 32'(bus.mem_wdata), 32'd0);
            chk("idle_done", 32'(bus.done), 32'd0);
        end
        if (bus.mem_we) begin
            if (wq.size() == 0) begin
                chk("unexpected_mem_we", 32'(bus.mem_we), 32'd0);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
                chk("wr_wdata", 32'(bus.mem_wdata), 32'(w.wdata));
                chk("wr_grant", 32'(bus.grant), 32'(1) << w.core);
                chk("wr_cycle", 32'(cyc), 32'(w.cyc));
            end
        end
        if (bus.done != 4'd0) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                done_t e;
                e = dq.pop_front();
                chk("done_vec", 32'(bus.done), 32'(1) << e.core);
                chk("done_grant", 32'(bus.grant), 32'(1) << e.core);
                chk("done_rdata", 32'(bus.rdata), 32'(e.rdata));
                chk("done_xfer_count", 32'(bus.xfer_count), 32'(e.xc));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Runs until all expectations drain; each core drops req on its done.
    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #1;
            bus.req = bus.req & ~bus.done;
            if (dq.size() == 0 && wq.size() == 0 && bus.req == 4'd0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle_timeout: pending done=%0d wr=%0d busy=%b", dq.size(), wq.size(), bus.busy);
            dq.delete();
            wq.delete();
            bus.req = '0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_xfer_count"}, 32'(bus.xfer_count), 32'd0);
    endtask

    int c0;
    int ndone;

    initial begin
        cyc = 0; n_checks = 0; n_errors = 0;
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[8'h10] = 16'h1234;
        for (int i = 0; i < 4; i++) ram[8'h40 + i] = 16'hA000 + 16'(i);
        ram[8'h50] = 16'h5555;
        ram[8'h60] = 16'h6666;
        bus.req = '0; bus.we = '0; bus.core_addr = '0; bus.core_wdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // Single read by core 2.
        c0 = cyc;
        set_core(2, 1'b0, 16'h0010, 16'h0000);
        push_done(2, 16'h1234, 16'd1, c0 + 3);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock); #1;
            chk("read_grant_window", 32'(bus.grant), 32'h4);
        end
        bus.req = bus.req & ~bus.done;
        wait_idle(20);

        // Single write by core 1; rdata keeps the previous read value.
        c0 = cyc;
        set_core(1, 1'b1, 16'h0020, 16'hBEEF);
        push_wr(16'h0020, 16'hBEEF, 1, c0 + 1);
        push_done(1, 16'h1234, 16'd2, c0 + 3);
        wait_idle(20);
        chk("write_ram", 32'(ram[8'h20]), 32'hBEEF);

        // All four cores request continuously out of reset.
        @(posedge clock); #1;
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            bus.we[n] = 1'b0;
            bus.core_addr[n*16 +: 16] = 16'h0040 + 16'(n);
        end
        bus.req = 4'hF;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        c0 = cyc;
        push_done(0, 16'hA000, 16'd1, c0 + 3);
        push_done(1, 16'hA001, 16'd2, c0 + 7);
        push_done(2, 16'hA002, 16'd3, c0 + 11);
        push_done(3, 16'hA003, 16'd4, c0 + 15);
        push_done(0, 16'hA000, 16'd5, c0 + 19);
        ndone = 0;
        for (int i = 0; i < 60 && ndone < 5; i++) begin
            @(posedge clock); #1;
            if (bus.done != 4'd0) ndone++;
            if (ndone == 5) bus.req = '0;
        end
        chk("rr_done_count", 32'(ndone), 32'd5);
        wait_idle(20);

        // Core 3 served last, then cores 0 and 3 together: 0 wins first.
        c0 = cyc;
        set_core(3, 1'b0, 16'h0043, 16'h0000);
        push_done(3, 16'hA003, 16'd6, c0 + 3);
        wait_idle(20);
        c0 = cyc;
        set_core(0, 1'b0, 16'h0040, 16'h0000);
        set_core(3, 1'b0, 16'h0043, 16'h0000);
        push_done(0, 16'hA000, 16'd7, c0 + 3);
        push_done(3, 16'hA003, 16'd8, c0 + 7);
        wait_idle(40);

        // Core 0 drops req and changes address after the latch.
        c0 = cyc;
        set_core(0, 1'b0, 16'h0050, 16'h0000);
        push_done(0, 16'h5555, 16'd9, c0 + 3);
        @(posedge clock); #1;
        chk("latch_grant", 32'(bus.grant), 32'h1);
        bus.req[0] = 1'b0;
        bus.core_addr[0 +: 16] = 16'h0060;
        wait_idle(20);

        // Reset during WAIT of a write abandons the transaction.
        c0 = cyc;
        set_core(1, 1'b1, 16'h0030, 16'h1111);
        push_wr(16'h0030, 16'h1111, 1, c0 + 1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        bus.req = '0;
        #1;
        check_reset_values("async_reset");
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        c0 = cyc;
        set_core(1, 1'b0, 16'h0030, 16'h0000);
        push_done(1, 16'h1111, 16'd1, c0 + 3);
        wait_idle(20);

        repeat (3) @(posedge clock);
        #1;
        chk("done_queue_empty", 32'(dq.size()), 32'd0);
        chk("wr_queue_empty", 32'(wq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, sets the data word width of cores and memory.
REQ-002 Parameter ADDR_W, default 16, sets the data memory address width.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  per-core access request; bit n = core n; level, held until done[n].
REQ-006 we  input  4  per-core write qualifier (1 = write, 0 = read); valid while req[n] is high.
REQ-007 core_addr  input  4*ADDR_W  per-core address; core n occupies bits [n*ADDR_W +: ADDR_W].
REQ-008 core_wdata  input  4*DATA_W  per-core write data; core n occupies bits [n*DATA_W +: DATA_W].
REQ-009 grant  output  4  one-hot owner of the memory port; all zero when idle.
REQ-010 done  output  4  one-cycle completion pulse to the granted core.
REQ-011 rdata  output  DATA_W  read result; valid in the done cycle; held until the next capture.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 mem_addr  output  ADDR_W  shared data memory address.
REQ-014 mem_wdata  output  DATA_W  shared data memory write data.
REQ-015 mem_we  output  1  shared data memory write strobe.
REQ-016 mem_rdata  input  DATA_W  synchronous RAM output; valid one cycle after the address is presented.
REQ-017 xfer_count  output  16  count of completed transactions; wraps from 16'hFFFF to 0.

Function
REQ-018 FSM states and transitions: IDLE -> ADDR -> WAIT -> DONE -> IDLE.
REQ-019 IDLE transition: if req != 0, select the winner, latch its we/addr/wdata and one-hot grant, then go to ADDR; otherwise remain in IDLE.
REQ-020 Winner selection is round-robin: search from core (last+1) mod 4 upward, wrapping; the first requesting core wins.
REQ-021 `last` updates to the winner index on entry to DONE.
REQ-022 ADDR state: drive mem_addr/mem_wdata from the latched values; mem_we = latched we for exactly this one cycle.
REQ-023 WAIT state: mem_addr is held and mem_we = 0; on a read, mem_rdata is captured into rdata at the end of the cycle.
REQ-024 On a write, rdata is unchanged.
REQ-025 DONE state: done[winner] = 1 for one cycle; grant still shows the winner; xfer_count increments.
REQ-026 grant clears on the return to IDLE.
REQ-027 Fixed latency: a req first seen in IDLE at cycle 0 gives grant from cycle 1, mem_we (if a write) in cycle 1, and done in cycle 3; the next grant is no earlier than cycle 5.
REQ-028 req is sampled only in IDLE; req/we/addr/wdata changes after the latch have no effect on the transaction in progress.
REQ-029 If req drops mid-transaction, the access still completes and done is still pulsed (no abort).
REQ-030 A req still high in the IDLE cycle after done is treated as a new request.
REQ-031 Simultaneous requests: exactly one grant; grant is always one-hot or zero.
REQ-032 A sole requester is granted regardless of the round-robin pointer.
REQ-033 mem_addr and mem_wdata are zero in IDLE.
REQ-034 done is never asserted outside the DONE state.

Reset
REQ-035 reset forces the following values immediately (asynchronously): state = IDLE, grant = 0, done = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, busy = 0, xfer_count = 0, last = 3 (core 0 has first priority).
REQ-036 A reset mid-transaction abandons the access: no done pulse and no counter increment.
REQ-037 After reset release, arbitration resumes at the first rising edge on which state is IDLE.

Verification
REQ-038 Single read: core 2 requests a read of addr 0x0010 with RAM[0x10] = 0x1234 -> grant = 0100 in cycles 1-3, mem_we always 0, done[2] in cycle 3, rdata = 0x1234, xfer_count = 1.
REQ-039 Single write: core 1 writes 0xBEEF to addr 0x0020 -> mem_we high in cycle 1 only with mem_addr = 0x0020 and mem_wdata = 0xBEEF, done[1] in cycle 3, rdata unchanged.
REQ-040 All four cores request continuously from reset -> grant order 0,1,2,3,0, one done every 4 cycles, no overlapping grants, xfer_count = 5.
REQ-041 Cores 0 and 3 request after core 3 was served last -> core 0 is granted first, then core 3.
REQ-042 Reset asserted during WAIT of a write -> outputs go to reset values without waiting for a clock edge, no done pulse, xfer_count = 0; a post-release request completes normally.
REQ-043 Core 0 drops req in ADDR and changes core_addr -> the transaction uses the latched address and done[0] still pulses in cycle 3.
